// File: rtl/rr_arbiter8_pkg.sv
// Shared definitions for the 8-way round-robin / fixed-priority arbiter:
// FSM state encodings, requester count, id width and a rotate helper.
package rr_arbiter8_pkg;

    localparam int NUM_REQ = 8;
    localparam int ID_W    = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Rotate a request vector right by sh, so bit sh lands on bit 0.
    function automatic logic [NUM_REQ-1:0] rotr(input logic [NUM_REQ-1:0] d,
                                                input logic [ID_W-1:0]    sh);
        logic [2*NUM_REQ-1:0] dd;
        dd = {d, d} >> sh;
        return dd[NUM_REQ-1:0];
    endfunction

endpackage

// File: rtl/rr_arbiter8_prio_enc8.sv
// 8-to-3 priority encoder. LOWEST_FIRST=1 picks the lowest set bit,
// otherwise the highest set bit wins. v flags that any bit is set.
module prio_enc8
    import rr_arbiter8_pkg::*;
#(
    parameter bit LOWEST_FIRST = 1'b0
) (
    input  logic [NUM_REQ-1:0] d,
    output logic [ID_W-1:0]    q,
    output logic               v
);

    // Scan toward the winning end so the last match is the priority winner.
    always_comb begin
        // NOTE: every output gets a default before any branch, so no latch is inferred.
        q = '0;
        v = |d;
        if (LOWEST_FIRST) begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (d[i]) q = ID_W'(i);
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (d[i]) q = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-requester arbiter with round-robin or fixed priority, a hold
// limit of MAX_HOLD cycles (legal 2..255, 2^CNT_W > MAX_HOLD) and one
// idle bubble between grants. The owner's done strobe is release_strb
// because "release" is a reserved word.
module rr_arbiter8
    import rr_arbiter8_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       release_strb,
    input  logic       fixed_mode,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);

    state_t             state, state_nxt;
    logic [ID_W-1:0]    ptr, ptr_nxt;
    logic [CNT_W-1:0]   hold_cnt, hold_cnt_nxt;
    logic [NUM_REQ-1:0] gnt_nxt;
    logic [ID_W-1:0]    gnt_id_nxt;
    logic               timeout_nxt;

    logic [NUM_REQ-1:0] req_rot;
    logic [ID_W-1:0]    fix_q, rot_q, winner;
    logic               fix_v, rot_v, any_req;
    logic               owner_req, at_limit, busy_end;

    assign req_rot = rotr(req, ptr);

    prio_enc8 #(.LOWEST_FIRST(1'b0)) u_enc_fixed (
        .d (req),
        .q (fix_q),
        .v (fix_v)
    );

    prio_enc8 #(.LOWEST_FIRST(1'b1)) u_enc_rr (
        .d (req_rot),
        .q (rot_q),
        .v (rot_v)
    );

    // Round-robin index is relative to ptr; the 3-bit add wraps mod 8.
    assign any_req   = fixed_mode ? fix_v : rot_v;
    assign winner    = fixed_mode ? fix_q : rot_q + ptr;
    assign owner_req = req[gnt_id];
    assign at_limit  = (hold_cnt == HOLD_LIM);
    assign busy_end  = release_strb || !owner_req || at_limit;
    assign gnt_valid = |gnt;

    // Next-state logic: grant from IDLE, hold or release from BUSY.
    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        hold_cnt_nxt = hold_cnt;
        gnt_nxt      = gnt;
        gnt_id_nxt   = gnt_id;
        timeout_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    gnt_nxt      = NUM_REQ'(1) << winner;
                    gnt_id_nxt   = winner;
                    hold_cnt_nxt = CNT_W'(1);
                    state_nxt    = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (busy_end) begin
                    gnt_nxt     = '0;
                    ptr_nxt     = gnt_id + ID_W'(1);
                    state_nxt   = ST_IDLE;
                    // release wins over the limit, so a coinciding release never times out
                    timeout_nxt = !release_strb && owner_req && at_limit;
                end else begin
                    hold_cnt_nxt = hold_cnt + CNT_W'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            gnt      <= '0;
            gnt_id   <= '0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            hold_cnt <= hold_cnt_nxt;
            gnt      <= gnt_nxt;
            gnt_id   <= gnt_id_nxt;
            timeout  <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Scenario bench for rr_arbiter8: each task builds a list of per-cycle
// stimulus with the expected outputs, pushes the expectation onto a
// scoreboard as the stimulus is driven, and compares after the edge.
module tb_rr_arbiter8;

    typedef struct packed {
        logic [7:0] gnt;
        logic [2:0] id;
        logic       valid;
        logic       to;
    } obs_t;

    typedef struct packed {
        logic       rst;
        logic [7:0] req;
        logic       rel;
        logic       fm;
        obs_t       exp;
    } step_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       release_strb;
    logic       fixed_mode;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    obs_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    rr_arbiter8 #(.MAX_HOLD(16), .CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .release_strb (release_strb),
        .fixed_mode   (fixed_mode),
        .gnt          (gnt),
        .gnt_id       (gnt_id),
        .gnt_valid    (gnt_valid),
        .timeout      (timeout)
    );

    function automatic step_t mk(input logic r, input logic [7:0] rq, input logic rl,
                                 input logic fm, input logic [7:0] g, input logic [2:0] id,
                                 input logic v, input logic to);
        step_t t;
        t.rst       = r;
        t.req       = rq;
        t.rel       = rl;
        t.fm        = fm;
        t.exp.gnt   = g;
        t.exp.id    = id;
        t.exp.valid = v;
        t.exp.to    = to;
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step_t s[$];
        obs_t  got, want;
        s.push_back(mk(1, 8'h00, 0, 0, 8'h00, 3'd0, 0, 0));
        s.push_back(mk(1, 8'h00, 0, 0, 8'h00, 3'd0, 0, 0));
        for (int i = 0; i < 10; i++) s.push_back(mk(0, 8'h00, 0, 0, 8'h00, 3'd0, 0, 0));
        foreach (s[k]) begin
            rst = s[k].rst; req = s[k].req; release_strb = s[k].rel; fixed_mode = s[k].fm;
            exp_q.push_back(s[k].exp);
            tick();
            want = exp_q.pop_front();
            got  = {gnt, gnt_id, gnt_valid, timeout};
            n_chk++;
            if (got !== want)
                $display("FAIL reset step %0d: got gnt=%h id=%0d v=%b to=%b, want gnt=%h id=%0d v=%b to=%b",
                         k, got.gnt, got.id, got.valid, got.to, want.gnt, want.id, want.valid, want.to);
            else n_pass++;
        end
    endtask

    task automatic test_round_robin();
        step_t      s[$];
        obs_t       got, want;
        logic [2:0] id;
        logic [7:0] g;
        for (int i = 0; i < 9; i++) begin
            id = 3'(i % 8);
            g  = 8'h01 << id;
            for (int c = 0; c < 3; c++) s.push_back(mk(0, 8'hFF, 0, 0, g, id, 1, 0));
            s.push_back(mk(0, 8'hFF, 1, 0, 8'h00, id, 0, 0));
        end
        foreach (s[k]) begin
            rst = s[k].rst; req = s[k].req; release_strb = s[k].rel; fixed_mode = s[k].fm;
            exp_q.push_back(s[k].exp);
            tick();
            want = exp_q.pop_front();
            got  = {gnt, gnt_id, gnt_valid, timeout};
            n_chk++;
            if (got !== want)
                $display("FAIL round_robin step %0d: got gnt=%h id=%0d v=%b to=%b, want gnt=%h id=%0d v=%b to=%b",
                         k, got.gnt, got.id, got.valid, got.to, want.gnt, want.id, want.valid, want.to);
            else n_pass++;
        end
    endtask

    task automatic test_fixed();
        step_t s[$];
        obs_t  got, want;
        s.push_back(mk(0, 8'h26, 0, 1, 8'h20, 3'd5, 1, 0));
        s.push_back(mk(0, 8'h26, 0, 1, 8'h20, 3'd5, 1, 0));
        s.push_back(mk(0, 8'h26, 1, 1, 8'h00, 3'd5, 0, 0));
        s.push_back(mk(0, 8'h26, 0, 1, 8'h20, 3'd5, 1, 0));
        s.push_back(mk(0, 8'h00, 0, 1, 8'h00, 3'd5, 0, 0));
        s.push_back(mk(0, 8'h00, 0, 1, 8'h00, 3'd5, 0, 0));
        foreach (s[k]) begin
            rst = s[k].rst; req = s[k].req; release_strb = s[k].rel; fixed_mode = s[k].fm;
            exp_q.push_back(s[k].exp);
            tick();
            want = exp_q.pop_front();
            got  = {gnt, gnt_id, gnt_valid, timeout};
            n_chk++;
            if (got !== want)
                $display("FAIL fixed step %0d: got gnt=%h id=%0d v=%b to=%b, want gnt=%h id=%0d v=%b to=%b",
                         k, got.gnt, got.id, got.valid, got.to, want.gnt, want.id, want.valid, want.to);
            else n_pass++;
        end
    endtask

    task automatic test_timeout();
        step_t s[$];
        obs_t  got, want;
        for (int i = 0; i < 16; i++) s.push_back(mk(0, 8'h08, 0, 0, 8'h08, 3'd3, 1, 0));
        s.push_back(mk(0, 8'h08, 0, 0, 8'h00, 3'd3, 0, 1));
        s.push_back(mk(0, 8'h08, 0, 0, 8'h08, 3'd3, 1, 0));
        s.push_back(mk(0, 8'h00, 0, 0, 8'h00, 3'd3, 0, 0));
        // release while idle has no effect
        s.push_back(mk(0, 8'h00, 1, 0, 8'h00, 3'd3, 0, 0));
        foreach (s[k]) begin
            rst = s[k].rst; req = s[k].req; release_strb = s[k].rel; fixed_mode = s[k].fm;
            exp_q.push_back(s[k].exp);
            tick();
            want = exp_q.pop_front();
            got  = {gnt, gnt_id, gnt_valid, timeout};
            n_chk++;
            if (got !== want)
                $display("FAIL timeout step %0d: got gnt=%h id=%0d v=%b to=%b, want gnt=%h id=%0d v=%b to=%b",
                         k, got.gnt, got.id, got.valid, got.to, want.gnt, want.id, want.valid, want.to);
            else n_pass++;
        end
    endtask

    task automatic test_owner_drop_and_simultaneous();
        step_t s[$];
        obs_t  got, want;
        for (int i = 0; i < 5; i++) s.push_back(mk(0, 8'h04, 0, 1, 8'h04, 3'd2, 1, 0));
        s.push_back(mk(0, 8'h00, 0, 1, 8'h00, 3'd2, 0, 0));
        s.push_back(mk(0, 8'h00, 0, 1, 8'h00, 3'd2, 0, 0));
        for (int i = 0; i < 16; i++) s.push_back(mk(0, 8'h04, 0, 1, 8'h04, 3'd2, 1, 0));
        s.push_back(mk(0, 8'h04, 1, 1, 8'h00, 3'd2, 0, 0));
        s.push_back(mk(0, 8'h00, 0, 1, 8'h00, 3'd2, 0, 0));
        foreach (s[k]) begin
            rst = s[k].rst; req = s[k].req; release_strb = s[k].rel; fixed_mode = s[k].fm;
            exp_q.push_back(s[k].exp);
            tick();
            want = exp_q.pop_front();
            got  = {gnt, gnt_id, gnt_valid, timeout};
            n_chk++;
            if (got !== want)
                $display("FAIL owner_drop step %0d: got gnt=%h id=%0d v=%b to=%b, want gnt=%h id=%0d v=%b to=%b",
                         k, got.gnt, got.id, got.valid, got.to, want.gnt, want.id, want.valid, want.to);
            else n_pass++;
        end
    endtask

    task automatic test_mid_grant_reset();
        step_t s[$];
        obs_t  got, want;
        s.push_back(mk(0, 8'h40, 0, 1, 8'h40, 3'd6, 1, 0));
        s.push_back(mk(0, 8'h40, 0, 1, 8'h40, 3'd6, 1, 0));
        s.push_back(mk(1, 8'h40, 0, 1, 8'h00, 3'd0, 0, 0));
        s.push_back(mk(0, 8'hFF, 0, 0, 8'h01, 3'd0, 1, 0));
        s.push_back(mk(0, 8'hFF, 1, 0, 8'h00, 3'd0, 0, 0));
        foreach (s[k]) begin
            rst = s[k].rst; req = s[k].req; release_strb = s[k].rel; fixed_mode = s[k].fm;
            exp_q.push_back(s[k].exp);
            tick();
            want = exp_q.pop_front();
            got  = {gnt, gnt_id, gnt_valid, timeout};
            n_chk++;
            if (got !== want)
                $display("FAIL mid_reset step %0d: got gnt=%h id=%0d v=%b to=%b, want gnt=%h id=%0d v=%b to=%b",
                         k, got.gnt, got.id, got.valid, got.to, want.gnt, want.id, want.valid, want.to);
            else n_pass++;
        end
    endtask

    initial begin
        rst          = 1'b1;
        req          = 8'h00;
        release_strb = 1'b0;
        fixed_mode   = 1'b0;
        test_reset();
        test_round_robin();
        test_fixed();
        test_timeout();
        test_owner_drop_and_simultaneous();
        test_mid_grant_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
